bmp_pixel_pack: RTL and testbench

Converts the raw byte stream of a 24-bit BMP file, as delivered by the SD card sector reader, into 32-bit pixel words for the frame buffer write port. Sits between the SD card byte reader and the frame read/write controller's write side, in the SD card clock domain. Strips the file header and per-row padding, reorders BMP B,G,R bytes into {R,G,B,8'h00} words, and runs the write_req/write_req_ack frame handshake before the first word.

---
 rtl/bmp_pixel_pack.sv | 159 +++++++++++++++
 tb/tb_bmp_pixel_pack.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bmp_pixel_pack.sv
// rtl/bmp_pixel_pack.sv - strips BMP header/row padding and packs B,G,R bytes into {R,G,B,00} words
module bmp_pixel_pack #(
    parameter int HEADER_BYTES = 54
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic [15:0] bmp_width,
    input  logic [15:0] bmp_height,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        write_req,
    input  logic        write_req_ack,
    output logic        write_en,
    output logic [31:0] write_data,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [2:0] {IDLE, REQ, HEADER, PIXEL, PAD, DONE} state_t;

    state_t      state;
    logic [15:0] width;
    logic [15:0] col;
    logic [15:0] hdr_cnt;
    logic [1:0]  pad;
    logic [1:0]  pad_cnt;
    logic [1:0]  phase;
    logic [31:0] total;
    logic [31:0] total_px;
    logic [7:0]  b_byte;
    logic [7:0]  g_byte;
    logic        take;
    logic        size_zero;

    assign take      = byte_valid & byte_ready;
    assign size_zero = (bmp_width == 16'd0) || (bmp_height == 16'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            width      <= 16'd0;
            col        <= 16'd0;
            hdr_cnt    <= 16'd0;
            pad        <= 2'd0;
            pad_cnt    <= 2'd0;
            phase      <= 2'd0;
            total      <= 32'd0;
            total_px   <= 32'd0;
            b_byte     <= 8'd0;
            g_byte     <= 8'd0;
            byte_ready <= 1'b0;
            write_req  <= 1'b0;
            write_en   <= 1'b0;
            write_data <= 32'd0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            write_en <= 1'b0;
            if (frame_start) begin
                // A new start always wins, including mid-frame: partial pixel is dropped.
                width      <= bmp_width;
                pad        <= bmp_width[1:0];
                total_px   <= bmp_width * bmp_height;
                col        <= 16'd0;
                hdr_cnt    <= 16'd0;
                pad_cnt    <= 2'd0;
                phase      <= 2'd0;
                total      <= 32'd0;
                byte_ready <= 1'b0;
                if (size_zero) begin
                    state      <= DONE;
                    write_req  <= 1'b0;
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                end else begin
                    state      <= REQ;
                    write_req  <= 1'b1;
                    busy       <= 1'b1;
                    frame_done <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: ;
                    REQ: begin
                        if (write_req_ack) begin
                            write_req  <= 1'b0;
                            byte_ready <= 1'b1;
                            state      <= HEADER;
                        end
                    end
                    HEADER: begin
                        if (take) begin
                            if (hdr_cnt == 16'(HEADER_BYTES - 1)) begin
                                hdr_cnt <= 16'd0;
                                state   <= PIXEL;
                            end else begin
                                hdr_cnt <= hdr_cnt + 16'd1;
                            end
                        end
                    end
                    PIXEL: begin
                        if (take) begin
                            case (phase)
                                2'd0: begin
                                    b_byte <= byte_data;
                                    phase  <= 2'd1;
                                end
                                2'd1: begin
                                    g_byte <= byte_data;
                                    phase  <= 2'd2;
                                end
                                default: begin
                                    phase      <= 2'd0;
                                    write_en   <= 1'b1;
                                    write_data <= {byte_data, g_byte, b_byte, 8'h00};
                                    total      <= total + 32'd1;
                                    // Final row padding is never read; the reader stops at the last pixel.
                                    if (total + 32'd1 == total_px) begin
                                        byte_ready <= 1'b0;
                                        state      <= DONE;
                                    end else if (col == width - 16'd1) begin
                                        col <= 16'd0;
                                        if (pad != 2'd0) state <= PAD;
                                    end else begin
                                        col <= col + 16'd1;
                                    end
                                end
                            endcase
                        end
                    end
                    PAD: begin
                        if (take) begin
                            if (pad_cnt == pad - 2'd1) begin
                                pad_cnt <= 2'd0;
                                state   <= PIXEL;
                            end else begin
                                pad_cnt <= pad_cnt + 2'd1;
                            end
                        end
                    end
                    DONE: begin
                        // Entered with frame_done low after the last word, high for a zero-size frame.
                        if (!frame_done) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            frame_done <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bmp_pixel_pack.sv
// tb/tb_bmp_pixel_pack.sv - scoreboard bench for bmp_pixel_pack
module tb_bmp_pixel_pack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [15:0] bmp_width = 16'd0;
    logic [15:0] bmp_height = 16'd0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready;
    logic        write_req;
    logic        write_req_ack = 1'b0;
    logic        write_en;
    logic [31:0] write_data;
    logic        busy;
    logic        frame_done;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_we_cyc = 0;
    int          we_count = 0;
    int          done_count = 0;
    int          seq = 1;
    logic [31:0] exp_q[$];
    logic [7:0]  byte_q[$];

    bmp_pixel_pack #(.HEADER_BYTES(54)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .bmp_width(bmp_width), .bmp_height(bmp_height),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .write_req(write_req), .write_req_ack(write_req_ack),
        .write_en(write_en), .write_data(write_data),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (write_en) begin
            we_count++;
            last_we_cyc = cyc;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            check_eq("word", write_data, e);
        end
        if (frame_done) done_count++;
    end

    // Build file bytes; mode 0 = counting bytes, 1 = constant B,G,R 10/20/30, 2 = random.
    task automatic build_frame(input int w, input int h, input int mode, input int npix);
        logic [7:0] b, g, r;
        int n;
        n = 0;
        byte_q.delete();
        if (mode == 0) seq = 1;
        for (int i = 0; i < 54; i++) byte_q.push_back(8'($urandom_range(0, 255)));
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (n < npix) begin
                    case (mode)
                        0: begin b = 8'(seq); g = 8'(seq + 1); r = 8'(seq + 2); seq += 3; end
                        1: begin b = 8'h10; g = 8'h20; r = 8'h30; end
                        default: begin
                            b = 8'($urandom_range(0, 255));
                            g = 8'($urandom_range(0, 255));
                            r = 8'($urandom_range(0, 255));
                        end
                    endcase
                    byte_q.push_back(b);
                    byte_q.push_back(g);
                    byte_q.push_back(r);
                    exp_q.push_back({r, g, b, 8'h00});
                    n++;
                    if (x == w - 1 && n != w * h)
                        for (int p = 0; p < (w % 4); p++) byte_q.push_back(8'hEE);
                end
            end
        end
    endtask

    task automatic pulse_start(input int w, input int h);
        @(negedge clk);
        bmp_width   = 16'(w);
        bmp_height  = 16'(h);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic do_ack();
        write_req_ack = 1'b1;
        @(negedge clk);
        write_req_ack = 1'b0;
    endtask

    task automatic send_bytes(input int duty);
        int  tries;
        bit  sent;
        bit  stuck;
        stuck = 1'b0;
        for (int i = 0; i < byte_q.size() && !stuck; i++) begin
            tries = 0;
            sent  = 1'b0;
            while (!sent && !stuck) begin
                @(negedge clk);
                byte_data  = byte_q[i];
                byte_valid = ($urandom_range(0, 99) < duty);
                if (byte_valid && byte_ready) sent = 1'b1;
                tries++;
                if (tries > 1000) begin
                    stuck = 1'b1;
                    check_eq("byte_accept_timeout", 32'(i), 32'(byte_q.size()));
                end
            end
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input int exp_words);
        int t;
        t = 0;
        while (!frame_done && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_eq("frame_done_seen", 32'(frame_done), 32'd1);
        check_eq("done_latency", 32'(cyc - last_we_cyc), 32'd1);
        check_eq("busy_at_done", 32'(busy), 32'd0);
        check_eq("word_count", 32'(we_count), 32'(exp_words));
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check_eq("done_pulse_width", 32'(frame_done), 32'd0);
    endtask

    task automatic start_and_ack(input int w, input int h);
        pulse_start(w, h);
        check_eq("busy_after_start", 32'(busy), 32'd1);
        check_eq("req_after_start", 32'(write_req), 32'd1);
        check_eq("ready_in_req", 32'(byte_ready), 32'd0);
        do_ack();
        check_eq("req_after_ack", 32'(write_req), 32'd0);
        check_eq("ready_after_ack", 32'(byte_ready), 32'd1);
    endtask

    initial begin
        int bad;
        int done_before;

        repeat (3) @(negedge clk);
        check_eq("rst_byte_ready", 32'(byte_ready), 32'd0);
        check_eq("rst_write_req", 32'(write_req), 32'd0);
        check_eq("rst_write_en", 32'(write_en), 32'd0);
        check_eq("rst_write_data", write_data, 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;

        // 4x2 counting bytes, no padding
        we_count = 0;
        build_frame(4, 2, 0, 8);
        start_and_ack(4, 2);
        send_bytes(100);
        wait_done(8);

        // 3x2 with 3 pad bytes of 0xEE per row
        we_count = 0;
        build_frame(3, 2, 1, 6);
        start_and_ack(3, 2);
        send_bytes(100);
        wait_done(6);

        // Acknowledge held off 20 cycles while bytes are offered
        we_count = 0;
        build_frame(5, 1, 2, 5);
        pulse_start(5, 1);
        byte_valid = 1'b1;
        byte_data  = byte_q[0];
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!write_req || byte_ready) bad++;
        end
        byte_valid = 1'b0;
        check_eq("req_hold_violations", 32'(bad), 32'd0);
        do_ack();
        check_eq("ready_after_late_ack", 32'(byte_ready), 32'd1);
        send_bytes(100);
        wait_done(5);

        // 640x2 random data at 30% byte_valid duty
        we_count = 0;
        build_frame(640, 2, 2, 1280);
        start_and_ack(640, 2);
        send_bytes(30);
        wait_done(1280);

        // Abort after 5 words plus a partial pixel, then a full 2x2 frame
        we_count = 0;
        done_before = done_count;
        build_frame(4, 3, 2, 5);
        byte_q.push_back(8'hA5);
        byte_q.push_back(8'h5A);
        start_and_ack(4, 3);
        send_bytes(100);
        repeat (3) @(negedge clk);
        check_eq("abort_words", 32'(we_count), 32'd5);
        we_count = 0;
        build_frame(2, 2, 0, 4);
        start_and_ack(2, 2);
        check_eq("no_done_on_abort", 32'(done_count), 32'(done_before));
        send_bytes(100);
        wait_done(4);

        // Zero height: immediate done, no request
        pulse_start(5, 0);
        check_eq("zero_done", 32'(frame_done), 32'd1);
        check_eq("zero_no_req", 32'(write_req), 32'd0);
        check_eq("zero_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_eq("zero_done_pulse", 32'(frame_done), 32'd0);

        // Asynchronous reset in the middle of a frame
        build_frame(4, 2, 2, 8);
        while (byte_q.size() > 61) void'(byte_q.pop_back());
        start_and_ack(4, 2);
        send_bytes(100);
        check_eq("busy_before_reset", 32'(busy), 32'd1);
        exp_q.delete();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_byte_ready", 32'(byte_ready), 32'd0);
        check_eq("arst_write_req", 32'(write_req), 32'd0);
        check_eq("arst_write_en", 32'(write_en), 32'd0);
        check_eq("arst_write_data", write_data, 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
